// File: rtl/tlul_host_arbiter.sv
// TL-UL payload types and a round-robin arbiter that shares one TL-UL device port
// between NHosts hosts, routing D-channel responses in order through a grant FIFO.
package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

endpackage

module tlul_host_arbiter #(
  parameter int unsigned NHosts      = 2,
  parameter int unsigned MaxOutstand = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  tlul_pkg::tl_h2d_t                  tl_h_i [NHosts],
  output tlul_pkg::tl_d2h_t                  tl_h_o [NHosts],
  output tlul_pkg::tl_h2d_t                  tl_d_o,
  input  tlul_pkg::tl_d2h_t                  tl_d_i,
  output logic [$clog2(MaxOutstand+1)-1:0]   outstanding_o,
  output logic                               err_o
);

  localparam int unsigned IdxW = $clog2(NHosts);
  localparam int unsigned PtrW = (MaxOutstand > 1) ? $clog2(MaxOutstand) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstand + 1);

  logic [IdxW-1:0] rr_q, rr_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic            lock_q, lock_d;
  logic            err_q, err_d;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [IdxW-1:0] fifo_q [MaxOutstand];

  logic [IdxW-1:0] grant, cand, head;
  logic            found, full, empty, push, pop, locked_valid;

  assign full         = (cnt_q == CntW'(MaxOutstand));
  assign empty        = (cnt_q == '0);
  assign head         = fifo_q[rptr_q];
  assign locked_valid = tl_h_i[lock_idx_q].a_valid;

  // Grant: held while locked, otherwise first requester at or above the rr pointer.
  always_comb begin
    grant = lock_idx_q;
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      found = locked_valid;
    end else begin
      for (int unsigned i = 0; i < NHosts; i++) begin
        cand = IdxW'((32'(rr_q) + i) % NHosts);
        if (!found && tl_h_i[cand].a_valid) begin
          found = 1'b1;
          grant = cand;
        end
      end
    end
  end

  // A/D channel steering and next-state; a_ready only sees the registered count.
  always_comb begin
    tl_d_o     = '0;
    push       = 1'b0;
    pop        = 1'b0;
    rr_d       = rr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    err_d      = err_q;
    for (int unsigned h = 0; h < NHosts; h++) begin
      tl_h_o[h]         = tl_d_i;
      tl_h_o[h].a_ready = 1'b0;
      tl_h_o[h].d_valid = 1'b0;
    end

    if (found) tl_d_o = tl_h_i[grant];
    tl_d_o.a_valid        = found & ~full & ~rst_i;
    tl_d_o.d_ready        = 1'b1;
    tl_h_o[grant].a_ready = found & tl_d_i.a_ready & ~full & ~rst_i;
    push = tl_d_o.a_valid & tl_d_i.a_ready;

    if (push) begin
      rr_d   = IdxW'((32'(grant) + 1) % NHosts);
      lock_d = 1'b0;
      wptr_d = (wptr_q == PtrW'(MaxOutstand - 1)) ? '0 : wptr_q + PtrW'(1);
    end else if (tl_d_o.a_valid) begin
      lock_d     = 1'b1;
      lock_idx_d = grant;
    end

    if (!empty) begin
      tl_h_o[head].d_valid = tl_d_i.d_valid & ~rst_i;
      tl_d_o.d_ready       = tl_h_i[head].d_ready;
    end else if (tl_d_i.d_valid) begin
      err_d = 1'b1;
    end
    pop = ~empty & tl_d_i.d_valid & tl_d_o.d_ready;
    if (pop) rptr_d = (rptr_q == PtrW'(MaxOutstand - 1)) ? '0 : rptr_q + PtrW'(1);

    cnt_d = cnt_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstand; i++) fifo_q[i] <= '0;
    end else begin
      rr_q       <= rr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      if (push) fifo_q[wptr_q] <= grant;
    end
  end

  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  a_lock_hold:    assert property (@(posedge clk_i) disable iff (rst_i) lock_q |-> locked_valid);

endmodule
